// File: rtl/axi4_ax_fifo_buffer_if.sv
// ---------------------------------------------------------------------------
// axi4_ax_fifo_buffer_if
//  AXI4 address-channel (AR or AW) bundle: payload fields plus valid/ready.
//  The same bundle serves both sides of the address-channel FIFO.
//
//  Signals
//    axid    [ID_W-1:0]    transaction ID
//    axaddr  [ADDR_W-1:0]  start address
//    axlen   [7:0]         burst length - 1
//    axsize  [2:0]         beat size
//    axburst [1:0]         burst type
//    axlock                exclusive access
//    axprot  [2:0]         protection attributes
//    axcache [3:0]         memory attributes
//    axuser  [USER_W-1:0]  user sideband
//    axvalid               request valid (source -> sink)
//    axready               request ready (sink -> source)
//
//  Modports
//    master : drives the request, receives ready
//    slave  : receives the request, drives ready
// ---------------------------------------------------------------------------
interface axi4_ax_fifo_buffer_if #(
    parameter int ID_W   = 4,
    parameter int USER_W = 4,
    parameter int ADDR_W = 32
);
    logic [ID_W-1:0]   axid;
    logic [ADDR_W-1:0] axaddr;
    logic [7:0]        axlen;
    logic [2:0]        axsize;
    logic [1:0]        axburst;
    logic              axlock;
    logic [2:0]        axprot;
    logic [3:0]        axcache;
    logic [USER_W-1:0] axuser;
    logic              axvalid;
    logic              axready;

    modport master (
        output axid, axaddr, axlen, axsize, axburst, axlock, axprot, axcache, axuser, axvalid,
        input  axready
    );

    modport slave (
        input  axid, axaddr, axlen, axsize, axburst, axlock, axprot, axcache, axuser, axvalid,
        output axready
    );
endinterface

// File: rtl/axi4_ax_fifo_buffer.sv
// ---------------------------------------------------------------------------
// axi4_ax_fifo_buffer
//  C_DEPTH-entry FIFO for one AXI4 address channel (AR or AW), placed between
//  the RAB slave port and the translation stage. Payload passes bit-exact and
//  in order. Reports its fill level and an almost-full flag, and accepts a
//  gate input that holds off presenting the next head entry downstream.
//
//  Ports
//    axi4_aclk    in   clock
//    axi4_arst    in   asynchronous reset, active-high
//    s_axi4       slave side address channel (requests come in here)
//    m_axi4       master side address channel (requests go out here)
//    gate         in   1 = do not start presenting a new head entry
//    level        out  current entry count, 0..C_DEPTH
//    almost_full  out  level >= C_AFULL_THRESH
// ---------------------------------------------------------------------------
module axi4_ax_fifo_buffer #(
    parameter int C_AXI_ID_WIDTH   = 4,
    parameter int C_AXI_USER_WIDTH = 4,
    parameter int C_ADDR_WIDTH     = 32,
    parameter int C_DEPTH          = 4,
    parameter int C_AFULL_THRESH   = 3
) (
    input  logic                       axi4_aclk,
    input  logic                       axi4_arst,
    axi4_ax_fifo_buffer_if.slave       s_axi4,
    axi4_ax_fifo_buffer_if.master      m_axi4,
    input  logic                       gate,
    output logic [$clog2(C_DEPTH):0]   level,
    output logic                       almost_full
);

    localparam int PTR_W   = $clog2(C_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int ENTRY_W = 21 + C_ADDR_WIDTH + C_AXI_ID_WIDTH + C_AXI_USER_WIDTH;

    logic [ENTRY_W-1:0] mem_q [C_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               s_ready_q, s_ready_d;
    logic               presented_q, presented_d;

    logic               push;
    logic               pop;
    logic               m_valid;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    // Entry packing, LSB first: cache, prot, lock, burst, size, len, addr, id, user.
    assign wr_entry = {s_axi4.axuser, s_axi4.axid, s_axi4.axaddr, s_axi4.axlen,
                       s_axi4.axsize, s_axi4.axburst, s_axi4.axlock, s_axi4.axprot,
                       s_axi4.axcache};

    assign rd_entry = mem_q[rd_ptr_q];

    assign {m_axi4.axuser, m_axi4.axid, m_axi4.axaddr, m_axi4.axlen,
            m_axi4.axsize, m_axi4.axburst, m_axi4.axlock, m_axi4.axprot,
            m_axi4.axcache} = rd_entry;

    // Once a request has been shown without being taken, it must stay up
    // regardless of gate; gate only blocks starting a fresh presentation.
    assign m_valid        = presented_q | (~gate & (level_q != '0));
    assign m_axi4.axvalid = m_valid;
    assign s_axi4.axready = s_ready_q;

    assign push = s_axi4.axvalid & s_ready_q;
    assign pop  = m_valid & m_axi4.axready;

    assign level       = level_q;
    assign almost_full = (level_q >= LVL_W'(C_AFULL_THRESH));

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        presented_d = presented_q;

        // Pointers are exactly PTR_W bits wide, so they wrap modulo C_DEPTH.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // Ready is registered from the next level so that it has no
        // combinational dependency on s_valid or m_ready.
        s_ready_d = (level_d != LVL_W'(C_DEPTH));

        if (pop) begin
            presented_d = 1'b0;
        end else if (m_valid) begin
            presented_d = 1'b1;
        end
    end

    always_ff @(posedge axi4_aclk or posedge axi4_arst) begin
        if (axi4_arst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            s_ready_q   <= 1'b0;
            presented_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            s_ready_q   <= s_ready_d;
            presented_q <= presented_d;
        end
    end

    // Storage carries no reset; the head is only looked at while level != 0.
    always_ff @(posedge axi4_aclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

endmodule

// File: tb/tb_axi4_ax_fifo_buffer.sv
module tb_axi4_ax_fifo_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       gate0, gate1;
    logic [2:0] level0;
    logic [1:0] level1;
    logic       afull0, afull1;

    int total = 0;
    int bad   = 0;
    int pops  = 0;

    logic [127:0] q0[$];
    logic [127:0] q1[$];

    always #5 clk = ~clk;

    axi4_ax_fifo_buffer_if #(.ID_W(4), .USER_W(4), .ADDR_W(32)) s0();
    axi4_ax_fifo_buffer_if #(.ID_W(4), .USER_W(4), .ADDR_W(32)) m0();
    axi4_ax_fifo_buffer_if #(.ID_W(4), .USER_W(4), .ADDR_W(64)) s1();
    axi4_ax_fifo_buffer_if #(.ID_W(4), .USER_W(4), .ADDR_W(64)) m1();

    axi4_ax_fifo_buffer #(
        .C_AXI_ID_WIDTH(4), .C_AXI_USER_WIDTH(4), .C_ADDR_WIDTH(32),
        .C_DEPTH(4), .C_AFULL_THRESH(3)
    ) dut0 (
        .axi4_aclk(clk), .axi4_arst(rst), .s_axi4(s0), .m_axi4(m0),
        .gate(gate0), .level(level0), .almost_full(afull0)
    );

    axi4_ax_fifo_buffer #(
        .C_AXI_ID_WIDTH(4), .C_AXI_USER_WIDTH(4), .C_ADDR_WIDTH(64),
        .C_DEPTH(2), .C_AFULL_THRESH(2)
    ) dut1 (
        .axi4_aclk(clk), .axi4_arst(rst), .s_axi4(s1), .m_axi4(m1),
        .gate(gate1), .level(level1), .almost_full(afull1)
    );

    logic [60:0] s0_word, m0_word;
    logic [92:0] s1_word, m1_word;

    assign s0_word = {s0.axuser, s0.axid, s0.axaddr, s0.axlen, s0.axsize, s0.axburst, s0.axlock, s0.axprot, s0.axcache};
    assign m0_word = {m0.axuser, m0.axid, m0.axaddr, m0.axlen, m0.axsize, m0.axburst, m0.axlock, m0.axprot, m0.axcache};
    assign s1_word = {s1.axuser, s1.axid, s1.axaddr, s1.axlen, s1.axsize, s1.axburst, s1.axlock, s1.axprot, s1.axcache};
    assign m1_word = {m1.axuser, m1.axid, m1.axaddr, m1.axlen, m1.axsize, m1.axburst, m1.axlock, m1.axprot, m1.axcache};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_s0(input logic [60:0] e);
        {s0.axuser, s0.axid, s0.axaddr, s0.axlen, s0.axsize, s0.axburst, s0.axlock, s0.axprot, s0.axcache} = e;
    endtask

    task automatic set_s1(input logic [92:0] e);
        {s1.axuser, s1.axid, s1.axaddr, s1.axlen, s1.axsize, s1.axburst, s1.axlock, s1.axprot, s1.axcache} = e;
    endtask

    function automatic logic [60:0] e0(input logic [3:0] user, input logic [3:0] id,
                                       input logic [31:0] addr, input logic [7:0] len,
                                       input logic [2:0] size, input logic [1:0] burst,
                                       input logic lock, input logic [2:0] prot,
                                       input logic [3:0] cache);
        return {user, id, addr, len, size, burst, lock, prot, cache};
    endfunction

    function automatic logic [60:0] e2(input int i);
        return e0(4'(i), 4'(i + 8), 32'h2000_0000 + 32'(i) * 32'h100, 8'(3 * i + 1),
                  3'(i), 2'(i), 1'(i % 2), 3'(7 - i), 4'(15 - i));
    endfunction

    // Scoreboard step evaluated just before the clock edge that samples the handshakes.
    task automatic sb_eval(input int w, input logic sv, input logic sr, input logic mv,
                           input logic mr, input logic [127:0] sw, input logic [127:0] mw);
        logic [127:0] exp;
        if (mv && mr) begin
            exp = '1;
            if (w == 0 && q0.size() > 0) exp = q0.pop_front();
            if (w == 1 && q1.size() > 0) exp = q1.pop_front();
            chk(w == 0 ? "sb0_pop" : "sb1_pop", mw, exp);
            pops++;
        end
        if (sv && sr) begin
            if (w == 0) q0.push_back(sw);
            else        q1.push_back(sw);
        end
    endtask

    // Master-side hold rule: valid without ready must persist with a stable payload.
    logic        pv0 = 1'b0, pr0 = 1'b0, pv1 = 1'b0, pr1 = 1'b0;
    logic [60:0] pw0 = '0;
    logic [92:0] pw1 = '0;

    always @(negedge clk) begin
        if (rst) begin
            pv0 <= 1'b0;
            pv1 <= 1'b0;
        end else begin
            if (pv0 && !pr0) chk("m0_hold", 128'({m0.axvalid, m0_word}), 128'({1'b1, pw0}));
            if (pv1 && !pr1) chk("m1_hold", 128'({m1.axvalid, m1_word}), 128'({1'b1, pw1}));
            pv0 <= m0.axvalid;
            pr0 <= m0.axready;
            pw0 <= m0_word;
            pv1 <= m1.axvalid;
            pr1 <= m1.axready;
            pw1 <= m1_word;
        end
    end

    initial begin
        logic [60:0] a1, g0, g1, nw;
        logic [63:0] r2;
        logic [95:0] r3;
        logic        pend;

        rst = 1'b1;
        gate0 = 1'b0; gate1 = 1'b0;
        s0.axvalid = 1'b0; m0.axready = 1'b0; set_s0('0);
        s1.axvalid = 1'b0; m1.axready = 1'b0; set_s1('0);

        // Reset state
        tick(); tick();
        chk("rst_s_ready", 128'(s0.axready), 128'(0));
        chk("rst_m_valid", 128'(m0.axvalid), 128'(0));
        chk("rst_level", 128'(level0), 128'(0));
        chk("rst_afull", 128'(afull0), 128'(0));
        chk("rst_m1_valid", 128'(m1.axvalid), 128'(0));
        rst = 1'b0;
        tick();
        chk("rel_s_ready", 128'(s0.axready), 128'(1));
        chk("rel_s1_ready", 128'(s1.axready), 128'(1));

        // Single entry with downstream ready
        a1 = e0(4'h5, 4'h3, 32'h1000_0040, 8'd7, 3'd2, 2'b01, 1'b0, 3'b010, 4'b0011);
        m0.axready = 1'b1;
        set_s0(a1); s0.axvalid = 1'b1;
        tick();
        s0.axvalid = 1'b0;
        chk("t1_m_valid", 128'(m0.axvalid), 128'(1));
        chk("t1_payload", 128'(m0_word), 128'(a1));
        chk("t1_level1", 128'(level0), 128'(1));
        tick();
        chk("t1_level0", 128'(level0), 128'(0));
        chk("t1_m_idle", 128'(m0.axvalid), 128'(0));

        // Fill to full with downstream stalled
        m0.axready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_s0(e2(i)); s0.axvalid = 1'b1;
            tick();
            chk("t2_level", 128'(level0), 128'(i + 1));
            chk("t2_afull", 128'(afull0), 128'(i >= 2));
            chk("t2_s_ready", 128'(s0.axready), 128'(i < 3));
        end
        set_s0(e2(4));
        tick();
        chk("t2_full_level", 128'(level0), 128'(4));
        chk("t2_full_ready", 128'(s0.axready), 128'(0));
        chk("t2_head", 128'(m0_word), 128'(e2(0)));
        m0.axready = 1'b1; s0.axvalid = 1'b0;
        #1;
        chk("t2_pop0_valid", 128'(m0.axvalid), 128'(1));
        chk("t2_pop0", 128'(m0_word), 128'(e2(0)));
        tick();
        chk("t2_lvl3", 128'(level0), 128'(3));
        chk("t2_ready_back", 128'(s0.axready), 128'(1));
        chk("t2_afull3", 128'(afull0), 128'(1));
        chk("t2_pop1", 128'(m0_word), 128'(e2(1)));
        tick();
        chk("t2_afull2", 128'(afull0), 128'(0));
        chk("t2_pop2", 128'(m0_word), 128'(e2(2)));
        tick();
        chk("t2_lvl1", 128'(level0), 128'(1));
        chk("t2_pop3", 128'(m0_word), 128'(e2(3)));
        tick();
        chk("t2_empty", 128'(level0), 128'(0));
        chk("t2_m_idle", 128'(m0.axvalid), 128'(0));

        // Streaming: one transfer per cycle, level constant
        pops = 0;
        s0.axvalid = 1'b1;
        for (int c = 0; c < 100; c++) begin
            r2 = {$urandom, $urandom};
            set_s0(r2[60:0]);
            #1;
            sb_eval(0, s0.axvalid, s0.axready, m0.axvalid, m0.axready, 128'(s0_word), 128'(m0_word));
            tick();
            chk("t3_level", 128'(level0), 128'(1));
        end
        chk("t3_pops", 128'(pops), 128'(99));
        s0.axvalid = 1'b0;
        #1;
        sb_eval(0, s0.axvalid, s0.axready, m0.axvalid, m0.axready, 128'(s0_word), 128'(m0_word));
        tick();
        chk("t3_drained", 128'(q0.size()), 128'(0));
        chk("t3_level0", 128'(level0), 128'(0));

        // Gate holds off presentation but never retracts a shown request
        g0 = e0(4'h9, 4'h1, 32'hDEAD_BEE0, 8'd0, 3'd3, 2'b10, 1'b1, 3'b111, 4'b1111);
        g1 = e0(4'h6, 4'hE, 32'h0000_0004, 8'd255, 3'd0, 2'b00, 1'b0, 3'b000, 4'b0000);
        gate0 = 1'b1; m0.axready = 1'b0;
        set_s0(g0); s0.axvalid = 1'b1;
        tick();
        chk("t4_gated1", 128'(m0.axvalid), 128'(0));
        set_s0(g1);
        tick();
        s0.axvalid = 1'b0;
        chk("t4_level2", 128'(level0), 128'(2));
        chk("t4_gated2", 128'(m0.axvalid), 128'(0));
        tick();
        chk("t4_gated3", 128'(m0.axvalid), 128'(0));
        gate0 = 1'b0;
        #1;
        chk("t4_open_valid", 128'(m0.axvalid), 128'(1));
        chk("t4_open_word", 128'(m0_word), 128'(g0));
        tick();
        chk("t4_hold_valid", 128'(m0.axvalid), 128'(1));
        gate0 = 1'b1;
        #1;
        chk("t4_regate_valid", 128'(m0.axvalid), 128'(1));
        chk("t4_regate_word", 128'(m0_word), 128'(g0));
        tick();
        chk("t4_regate2_valid", 128'(m0.axvalid), 128'(1));
        chk("t4_regate2_word", 128'(m0_word), 128'(g0));
        m0.axready = 1'b1;
        tick();
        chk("t4_after_pop_valid", 128'(m0.axvalid), 128'(0));
        chk("t4_after_pop_level", 128'(level0), 128'(1));
        gate0 = 1'b0;
        #1;
        chk("t4_g1_valid", 128'(m0.axvalid), 128'(1));
        chk("t4_g1_word", 128'(m0_word), 128'(g1));
        tick();
        chk("t4_empty", 128'(level0), 128'(0));
        m0.axready = 1'b0;

        // Asynchronous reset with three entries queued
        for (int i = 0; i < 3; i++) begin
            set_s0(e2(i + 5)); s0.axvalid = 1'b1;
            tick();
        end
        s0.axvalid = 1'b0;
        chk("t5_level3", 128'(level0), 128'(3));
        chk("t5_valid", 128'(m0.axvalid), 128'(1));
        rst = 1'b1;
        #1;
        chk("t5_async_valid", 128'(m0.axvalid), 128'(0));
        chk("t5_async_level", 128'(level0), 128'(0));
        chk("t5_async_ready", 128'(s0.axready), 128'(0));
        chk("t5_async_afull", 128'(afull0), 128'(0));
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("t5_rel_ready", 128'(s0.axready), 128'(1));
        nw = e0(4'hC, 4'h7, 32'h8000_1234, 8'd15, 3'd4, 2'b01, 1'b0, 3'b001, 4'b0110);
        set_s0(nw); s0.axvalid = 1'b1; m0.axready = 1'b1;
        tick();
        s0.axvalid = 1'b0;
        chk("t5_first_valid", 128'(m0.axvalid), 128'(1));
        chk("t5_first_word", 128'(m0_word), 128'(nw));
        chk("t5_first_level", 128'(level0), 128'(1));
        tick();
        chk("t5_empty", 128'(level0), 128'(0));
        m0.axready = 1'b0;

        // Random stress on the 2-deep, 64-bit-address instance
        pend = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!pend) begin
                if ($urandom_range(0, 9) < 6) begin
                    r3 = {$urandom, $urandom, $urandom};
                    set_s1(r3[92:0]);
                    s1.axvalid = 1'b1;
                end else begin
                    s1.axvalid = 1'b0;
                end
            end
            m1.axready = ($urandom_range(0, 1) == 1);
            gate1 = ($urandom_range(0, 3) == 0);
            #1;
            pend = s1.axvalid & ~s1.axready;
            sb_eval(1, s1.axvalid, s1.axready, m1.axvalid, m1.axready, 128'(s1_word), 128'(m1_word));
            tick();
            chk("t6_level_max", 128'(level1 <= 2'd2), 128'(1));
            chk("t6_afull", 128'(afull1), 128'(level1 == 2'd2));
            chk("t6_s_ready", 128'(s1.axready), 128'(level1 != 2'd2));
        end
        s1.axvalid = 1'b0; gate1 = 1'b0; m1.axready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            sb_eval(1, s1.axvalid, s1.axready, m1.axvalid, m1.axready, 128'(s1_word), 128'(m1_word));
            tick();
        end
        chk("t6_drained", 128'(q1.size()), 128'(0));
        chk("t6_level0", 128'(level1), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
